// File: rtl/icache_fill_if.sv
// Fetch/fill bus for icache_fill: requester side (pc/req/instr) and backing-store side
// (miss/missedPC/fill). Bit 0 is the MSB of every vector.
interface icache_fill_if;
   logic [0:31]       pc;
   logic              req;
   logic [0:31]       instr;
   logic              instr_valid;
   logic              stall;
   logic              miss;
   logic [0:31]       missedPC;
   logic              fill_valid;
   logic [0:31][0:31] fill_data;

   modport master (
      output pc, req, fill_valid, fill_data,
      input  instr, instr_valid, stall, miss, missedPC
   );

   modport slave (
      input  pc, req, fill_valid, fill_data,
      output instr, instr_valid, stall, miss, missedPC
   );
endinterface

// File: rtl/icache_fill.sv
// Direct-mapped 4-line x 32-word instruction cache with a single outstanding line fill.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module icache_fill (
   input  logic         clk,
   input  logic         reset,
   icache_fill_if.slave bus
`ifdef ICACHE_STATS_EN
   ,
   output logic [15:0]  hit_count,
   output logic [15:0]  miss_count
`endif
);

   typedef enum logic [1:0] {IDLE, MISS, WAIT} state_t;

   state_t            state;
   logic [0:31][0:31] lines [4];
   logic [0:22]       tags  [4];
   logic [3:0]        valid;
   logic [0:4]        miss_off;

   logic [0:4]        offset;
   logic [0:1]        index;
   logic [0:22]       tag;
   logic [0:1]        fill_index;
   logic              hit;
   logic              fill_fire;
   logic              unused_pc_lsbs;

   assign offset         = bus.pc[25:29];
   assign index          = bus.pc[23:24];
   assign tag            = bus.pc[0:22];
   assign fill_index     = bus.missedPC[23:24];
   assign hit            = valid[index] && (tags[index] == tag);
   assign fill_fire      = (state == WAIT) && bus.fill_valid;
   assign unused_pc_lsbs = ^bus.pc[30:31];

   // Line data and tags carry no reset; the valid bits alone gate hits.
   always_ff @(posedge clk) begin
      if (fill_fire) begin
         lines[fill_index] <= bus.fill_data;
         tags[fill_index]  <= bus.missedPC[0:22];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         valid           <= '0;
         miss_off        <= '0;
         bus.instr       <= '0;
         bus.instr_valid <= 1'b0;
         bus.stall       <= 1'b0;
         bus.miss        <= 1'b0;
         bus.missedPC    <= '0;
      end else begin
         bus.instr_valid <= 1'b0;
         bus.miss        <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req) begin
                  if (hit) begin
                     bus.instr       <= lines[index][offset];
                     bus.instr_valid <= 1'b1;
                  end else begin
                     bus.missedPC <= {bus.pc[0:24], 7'b0};
                     miss_off     <= offset;
                     bus.miss     <= 1'b1;
                     bus.stall    <= 1'b1;
                     state        <= MISS;
                  end
               end
            end
            MISS: state <= WAIT;
            WAIT: begin
               if (bus.fill_valid) begin
                  valid[fill_index] <= 1'b1;
                  // Forward the requested word straight from the fill bus.
                  bus.instr         <= bus.fill_data[miss_off];
                  bus.instr_valid   <= 1'b1;
                  bus.stall         <= 1'b0;
                  state             <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state == IDLE && bus.req) begin
         if (hit && hit_count != 16'hFFFF) begin
            hit_count <= hit_count + 16'd1;
         end
         if (!hit && miss_count != 16'hFFFF) begin
            miss_count <= miss_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: doc/icache_fill.md
ICACHE_FILL -- requirements
Module: icache_fill

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 pc  in  32 [0:31]  fetch address; word address = pc[0:29]; offset = pc[25:29], index = pc[23:24], tag = pc[0:22].
REQ-004 req  in  1  fetch request; sampled only when stall=0.
REQ-005 instr  out  32 [0:31]  fetched instruction, registered.
REQ-006 instr_valid  out  1  instr valid this cycle; one-cycle pulse per accepted req.
REQ-007 stall  out  1  high whenever state != IDLE; requester holds pc/req while high.
REQ-008 miss  out  1  line-fill request to backing store; one-cycle pulse.
REQ-009 missedPC  out  32 [0:31]  line-aligned miss address: pc[0:24] latched, bits [25:31] zero.
REQ-010 fill_valid  in  1  backing-store data valid (single-cycle).
REQ-011 fill_data  in  32x32 [0:31][0:31]  full line; word i = instruction at missedPC word address + i.

Function
REQ-012 Storage: 4 direct-mapped lines, each 32 words x 32 bits, plus 23-bit tag and 1 valid bit per line.
REQ-013 FSM states IDLE, MISS, WAIT; encoding free.
REQ-014 IDLE, req=1, hit (valid[index] and tag match): next cycle instr=line[index][offset], instr_valid=1; state stays IDLE (1-cycle latency, back-to-back hits at 1/cycle).
REQ-015 IDLE, req=1, miss: latch pc into missedPC (aligned), go MISS; instr_valid=0 next cycle.
REQ-016 MISS: miss=1 for exactly this cycle; go WAIT unconditionally.
REQ-017 WAIT: miss=0, missedPC held stable; stay until fill_valid=1; any wait length tolerated.
REQ-018 WAIT with fill_valid=1: write fill_data to line at latched index, set tag, set valid; next cycle instr=fill_data[latched offset], instr_valid=1, state IDLE.
REQ-019 stall = (state==MISS or state==WAIT); req and pc ignored while stall=1.
REQ-020 fill_valid in IDLE or MISS ignored; no array, tag or valid update.
REQ-021 Fill to a valid line overwrites it (no victim write-back; instruction memory read-only).
REQ-022 pc[30:31] ignored for lookup and missedPC.
REQ-023 instr holds last value when instr_valid=0.

Reset
REQ-024 On reset assertion, asynchronously: state=IDLE, all valid bits=0, instr=0, instr_valid=0, miss=0, missedPC=0, stall=0.
REQ-025 Reset during MISS or WAIT aborts the fill; a fill_valid after reset release is ignored (REQ-020).
REQ-026 Line data and tag arrays need not be reset.

Configuration
REQ-027 Macro ICACHE_STATS_EN defined: extra outputs hit_count and miss_count, 16 bits each, increment on each accepted hit / miss, saturate at 0xFFFF, reset to 0.
REQ-028 ICACHE_STATS_EN undefined: counters and their ports absent; all other behaviour identical.

Verification
REQ-029 Reset, req pc=0x00000040 -> next cycle stall=1, miss=1, missedPC=0x00000000; fill_valid 3 cycles later with word16=0xDEADBEEF -> next cycle instr=0xDEADBEEF, instr_valid=1, stall=0.
REQ-030 After REQ-029, req pc=0x00000044 then 0x00000048 back-to-back -> instr=word17, word18 on consecutive cycles, instr_valid=1 both, miss never asserted.
REQ-031 Line 0 filled for tag 0; req pc=0x00000200 (same index, tag 1) -> miss, missedPC=0x00000200; after fill, req pc=0x00000000 misses again.
REQ-032 Assert reset while in WAIT; release; pulse fill_valid -> no instr_valid; req pc=0x00000000 -> miss=1 (valid bits cleared).
REQ-033 fill_valid pulsed while IDLE with no miss pending -> no state change, subsequent req still misses.
REQ-034 With ICACHE_STATS_EN: 1 miss + 2 hits -> miss_count=1, hit_count=2; without macro the bench compiles without counter ports.
